// File: rtl/vga_pkg.sv
// Shared screen geometry, pixel types and the circle plotter state encoding.
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [2:0]        colour_t;
  typedef logic [7:0]        coord_x_t;
  typedef logic [6:0]        coord_y_t;
  typedef logic signed [9:0] s10_t;

  // Octant states sit at 0..7 so the low three bits double as the octant index.
  typedef enum logic [3:0] {
    OCT0 = 4'd0, OCT1 = 4'd1, OCT2 = 4'd2, OCT3 = 4'd3,
    OCT4 = 4'd4, OCT5 = 4'd5, OCT6 = 4'd6, OCT7 = 4'd7,
    IDLE = 4'd8, DONE = 4'd9
  } circle_state_t;
endpackage

// File: rtl/octant_point.sv
// Maps one midpoint offset pair into the k-th symmetric octant point and flags
// whether it lands on the visible screen.
module octant_point #(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic [2:0]        k,
  input  vga_pkg::s10_t     cx,
  input  vga_pkg::s10_t     cy,
  input  vga_pkg::s10_t     ox,
  input  vga_pkg::s10_t     oy,
  output vga_pkg::coord_x_t x,
  output vga_pkg::coord_y_t y,
  output logic              on_screen
);
  import vga_pkg::*;

  localparam s10_t XLIM = s10_t'(SCREEN_W);
  localparam s10_t YLIM = s10_t'(SCREEN_H);

  s10_t dx, dy, sx, sy;

  always_comb begin
    dx = ox;
    dy = oy;
    case (k)
      3'd0: begin dx =  ox; dy =  oy; end
      3'd1: begin dx =  oy; dy =  ox; end
      3'd2: begin dx = -ox; dy =  oy; end
      3'd3: begin dx = -oy; dy =  ox; end
      3'd4: begin dx = -ox; dy = -oy; end
      3'd5: begin dx = -oy; dy = -ox; end
      3'd6: begin dx =  ox; dy = -oy; end
      3'd7: begin dx =  oy; dy = -ox; end
      default: ;
    endcase
    sx = cx + dx;
    sy = cy + dy;
  end

  assign x         = sx[7:0];
  assign y         = sy[6:0];
  assign on_screen = !sx[9] && (sx < XLIM) && !sy[9] && (sy < YLIM);
endmodule

// File: rtl/circle_plotter.sv
// Midpoint circle outline generator: one candidate pixel per clock toward
// vga_adapter, eight symmetric points per iteration, off-screen points clipped.
module circle_plotter #(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  vga_pkg::colour_t  colour,
  input  vga_pkg::coord_x_t centre_x,
  input  vga_pkg::coord_y_t centre_y,
  input  logic [7:0]        radius,
  output logic              done,
  output vga_pkg::coord_x_t vga_x,
  output vga_pkg::coord_y_t vga_y,
  output vga_pkg::colour_t  vga_colour,
  output logic              vga_plot
);
  import vga_pkg::*;

  circle_state_t state, next_state;
  s10_t          cx_q, cy_q, ox_q, oy_q, crit_q;
  s10_t          cx_n, cy_n, ox_n, oy_n, crit_n;
  colour_t       col_q, col_n;
  coord_x_t      pt_x, x_d;
  coord_y_t      pt_y, y_d;
  logic          on_scr, is_oct, plot_d, done_d;

  // Datapath next values: latch in IDLE, midpoint step on the OCT7 edge.
  always_comb begin
    cx_n   = cx_q;
    cy_n   = cy_q;
    ox_n   = ox_q;
    oy_n   = oy_q;
    crit_n = crit_q;
    col_n  = col_q;
    if (state == IDLE && start) begin
      cx_n   = s10_t'({2'b00, centre_x});
      cy_n   = s10_t'({3'b000, centre_y});
      ox_n   = s10_t'({2'b00, radius});
      oy_n   = 10'sd0;
      crit_n = 10'sd1 - s10_t'({2'b00, radius});
      col_n  = colour;
    end else if (state == OCT7) begin
      oy_n = oy_q + 10'sd1;
      if (crit_q <= 10'sd0) begin
        crit_n = crit_q + (oy_n <<< 1) + 10'sd1;
      end else begin
        ox_n   = ox_q - 10'sd1;
        crit_n = crit_q + ((oy_n - ox_n) <<< 1) + 10'sd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? OCT0 : IDLE;
      OCT7:    next_state = (oy_n <= ox_n) ? OCT0 : DONE;
      DONE:    next_state = start ? DONE : IDLE;
      default: next_state = circle_state_t'(state + 4'd1);
    endcase
  end

  // Evaluated on next-cycle values so the registered pixel lines up with its state.
  octant_point #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_pt (
    .k        (next_state[2:0]),
    .cx       (cx_n),
    .cy       (cy_n),
    .ox       (ox_n),
    .oy       (oy_n),
    .x        (pt_x),
    .y        (pt_y),
    .on_screen(on_scr)
  );

  always_comb begin
    is_oct = !next_state[3];
    plot_d = is_oct && on_scr;
    done_d = (next_state == DONE);
    x_d    = is_oct ? pt_x : vga_x;
    y_d    = is_oct ? pt_y : vga_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q     <= '0;
      cy_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      crit_q   <= '0;
      col_q    <= '0;
      vga_x    <= '0;
      vga_y    <= '0;
      vga_plot <= 1'b0;
      done     <= 1'b0;
    end else begin
      cx_q     <= cx_n;
      cy_q     <= cy_n;
      ox_q     <= ox_n;
      oy_q     <= oy_n;
      crit_q   <= crit_n;
      col_q    <= col_n;
      vga_x    <= x_d;
      vga_y    <= y_d;
      vga_plot <= plot_d;
      done     <= done_d;
    end
  end

  assign vga_colour = col_q;
endmodule
